// File: rtl/idct_pkg.sv
// Shared constants, types and helpers for the 8x8 2D inverse DCT.
// Optional build macro IDCT_SAT_EN: saturate final samples and report clipping.
package idct_pkg;

    localparam int IN_W   = 12;  // signed coefficient width
    localparam int OUT_W  = 9;   // signed output sample width
    localparam int INT_W  = 24;  // internal accumulator width
    localparam int CF     = 7;   // fractional bits of the cosine constants
    localparam int KLAT   = 4;   // 1D kernel pipeline latency
    localparam int OUT_SH = 2;   // undoes the forward-path >>>2

    localparam int LOAD_CYC  = 65;
    localparam int PASS_CYC  = 8 + KLAT;
    localparam int WRITE_CYC = 64;

    typedef logic signed [INT_W-1:0] acc_t;
    typedef logic signed [7:0]       kcoef_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROW,
        S_COL,
        S_WRITE,
        S_DONE
    } state_t;

    localparam acc_t ROUND = acc_t'(2 ** (CF - 1));

    // K[k][n] = round(2^CF * C(k)/2 * cos((2n+1)k*pi/16)), frequency k selects the row.
    localparam kcoef_t K_TAB [8][8] = '{
        '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
        '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
        '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
        '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
        '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
        '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
        '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
        '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
    };

`ifdef IDCT_SAT_EN
    localparam acc_t OUT_MAX = acc_t'(2 ** (OUT_W - 1) - 1);
    localparam acc_t OUT_MIN = acc_t'(-(2 ** (OUT_W - 1)));

    // True when the scaled column result does not fit in OUT_W bits.
    function automatic logic is_clip(input acc_t v);
        acc_t s;
        s = v <<< OUT_SH;
        return (s > OUT_MAX) || (s < OUT_MIN);
    endfunction
`endif

    // Scale a column result back up and reduce it to the output sample width.
    function automatic logic signed [OUT_W-1:0] to_out(input acc_t v);
        acc_t s;
        s = v <<< OUT_SH;
`ifdef IDCT_SAT_EN
        if (s > OUT_MAX) begin
            s = OUT_MAX;
        end else if (s < OUT_MIN) begin
            s = OUT_MIN;
        end
`endif
        return s[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/idct_2d_top_kernel.sv
// One-dimensional 8-point IDCT kernel, fully pipelined, latency KLAT.
// Shared by the row and column passes; a 3-bit tag rides along with each vector.
module one_d_idct_kernel
    import idct_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_tag,
    input  acc_t       in_x [8],
    output logic       out_valid,
    output logic [2:0] out_tag,
    output acc_t       out_y [8]
);

    acc_t             res [8];
    acc_t             acc;
    acc_t             data_q [KLAT][8];
    acc_t             data_d [KLAT][8];
    logic [2:0]       tag_q  [KLAT];
    logic [2:0]       tag_d  [KLAT];
    logic [KLAT-1:0]  vld_q, vld_d;

    // Dot product of the input vector with each basis column, rounded back to CF=0.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch or loop, so no latch is inferred.
        acc = '0;
        for (int n = 0; n < 8; n++) begin
            acc = '0;
            for (int k = 0; k < 8; k++) begin
                acc = acc + in_x[k] * acc_t'(K_TAB[k][n]);
            end
            res[n] = (acc + ROUND) >>> CF;
        end
    end

    // Next value of each pipeline stage: new result enters stage 0, the rest shift by one.
    always_comb begin
        data_d[0] = res;
        tag_d[0]  = in_tag;
        for (int i = 1; i < KLAT; i++) begin
            data_d[i] = data_q[i-1];
            tag_d[i]  = tag_q[i-1];
        end
        vld_d = KLAT'({vld_q, in_valid});
    end

    // Valid bits must clear on reset so an aborted pass leaves nothing in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Datapath stages carry no reset; they are qualified by the valid chain.
    always_ff @(posedge Clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign out_valid = vld_q[KLAT-1];
    assign out_tag   = tag_q[KLAT-1];
    assign out_y     = data_q[KLAT-1];

endmodule

// File: rtl/idct_2d_top.sv
// 8x8 2D inverse DCT: load coefficients, row pass, column pass, write samples.
// Optional build macro IDCT_SAT_EN: saturating output with sticky Sat_flag.
module idct_2d_top
    import idct_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Start,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Coef_rd_en,
    output logic [5:0]              Coef_addr,
    input  logic signed [IN_W-1:0]  Coef_data,
    output logic                    Pix_wr_en,
    output logic [5:0]              Pix_addr,
    output logic signed [OUT_W-1:0] Pix_data,
    output logic                    Sat_flag
);

    state_t state_q, state_d;
    logic [6:0] cnt_q, cnt_d;

    logic signed [IN_W-1:0]  coef_buf [64];
    acc_t                    tp_buf   [64];
    logic signed [OUT_W-1:0] out_buf  [64];

    logic       k_in_vld, k_out_vld;
    logic [2:0] k_out_tag;
    acc_t       k_x [8];
    acc_t       k_y [8];

    logic                    pix_wr_en_q, pix_wr_en_d;
    logic [5:0]              pix_addr_q, pix_addr_d;
    logic signed [OUT_W-1:0] pix_data_q, pix_data_d;

    // Phase sequencing: each busy state runs for a fixed count, then advances.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 7'd1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Start) state_d = S_LOAD;
            end
            S_LOAD: if (cnt_q == 7'(LOAD_CYC - 1)) begin
                state_d = S_ROW;
                cnt_d   = '0;
            end
            S_ROW: if (cnt_q == 7'(PASS_CYC - 1)) begin
                state_d = S_COL;
                cnt_d   = '0;
            end
            S_COL: if (cnt_q == 7'(PASS_CYC - 1)) begin
                state_d = S_WRITE;
                cnt_d   = '0;
            end
            S_WRITE: if (cnt_q == 7'(WRITE_CYC - 1)) begin
                state_d = S_DONE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and phase counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done       = (state_q == S_DONE);
    assign Coef_rd_en = (state_q == S_LOAD) && !cnt_q[6];
    assign Coef_addr  = Coef_rd_en ? cnt_q[5:0] : 6'd0;

    // Read data lags the address by one cycle, so entry cnt-1 is captured.
    always_ff @(posedge Clk) begin
        // NOTE: buffer memories have no reset; their contents are always written before being read.
        if (state_q == S_LOAD && cnt_q != 7'd0) begin
            coef_buf[6'(cnt_q - 7'd1)] <= Coef_data;
        end
    end

    // Feed one row (ROW) or one transpose-buffer column (COL) per cycle for 8 cycles.
    always_comb begin
        k_in_vld = 1'b0;
        for (int k = 0; k < 8; k++) k_x[k] = '0;
        if (!cnt_q[6] && !cnt_q[5] && !cnt_q[4] && !cnt_q[3]) begin
            if (state_q == S_ROW) begin
                k_in_vld = 1'b1;
                for (int k = 0; k < 8; k++) k_x[k] = acc_t'(coef_buf[{cnt_q[2:0], 3'(k)}]);
            end else if (state_q == S_COL) begin
                k_in_vld = 1'b1;
                for (int k = 0; k < 8; k++) k_x[k] = tp_buf[{3'(k), cnt_q[2:0]}];
            end
        end
    end

    one_d_idct_kernel u_kernel (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (k_in_vld),
        .in_tag    (cnt_q[2:0]),
        .in_x      (k_x),
        .out_valid (k_out_vld),
        .out_tag   (k_out_tag),
        .out_y     (k_y)
    );

    // Row results fill transpose row <tag>; column results fill output column <tag>.
    always_ff @(posedge Clk) begin
        if (k_out_vld && state_q == S_ROW) begin
            for (int n = 0; n < 8; n++) tp_buf[{k_out_tag, 3'(n)}] <= k_y[n];
        end else if (k_out_vld && state_q == S_COL) begin
            for (int n = 0; n < 8; n++) out_buf[{3'(n), k_out_tag}] <= to_out(k_y[n]);
        end
    end

    // Pixel port is registered from the next state so writes line up with WRITE.
    always_comb begin
        pix_wr_en_d = (state_d == S_WRITE);
        pix_addr_d  = pix_wr_en_d ? cnt_d[5:0] : 6'd0;
        pix_data_d  = pix_wr_en_d ? out_buf[cnt_d[5:0]] : '0;
    end

    // Pixel write port registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pix_wr_en_q <= 1'b0;
            pix_addr_q  <= '0;
            pix_data_q  <= '0;
        end else begin
            pix_wr_en_q <= pix_wr_en_d;
            pix_addr_q  <= pix_addr_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign Pix_wr_en = pix_wr_en_q;
    assign Pix_addr  = pix_addr_q;
    assign Pix_data  = pix_data_q;

`ifdef IDCT_SAT_EN
    logic sat_q, sat_d, clip_any;

    // Sticky clip indicator, cleared by an accepted Start.
    always_comb begin
        clip_any = 1'b0;
        for (int n = 0; n < 8; n++) clip_any = clip_any | is_clip(k_y[n]);
        sat_d = sat_q;
        if (state_q == S_IDLE && Start) begin
            sat_d = 1'b0;
        end else if (state_q == S_COL && k_out_vld && clip_any) begin
            sat_d = 1'b1;
        end
    end

    // Saturation flag register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) sat_q <= 1'b0;
        else        sat_q <= sat_d;
    end

    assign Sat_flag = sat_q;
`else
    assign Sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_idct_2d_top.sv
// Self-checking bench for idct_2d_top: behavioural RAM models on both ports,
// a floating-point-derived cosine table and plain-integer reference IDCT.
module tb_idct_2d_top;

    localparam real PI     = 3.14159265358979;
    localparam int  DONE_T = 2 * (8 + 4) + 129;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              Start;
    logic              Busy, Done, Coef_rd_en, Pix_wr_en, Sat_flag;
    logic [5:0]        Coef_addr, Pix_addr;
    logic signed [11:0] Coef_data;
    logic signed [8:0]  Pix_data;

    int n_checks = 0;
    int n_err    = 0;

    int kr [8][8];
    int coef_blk [64];
    int exp_pix  [64];
    int exp_sat;
    int pix_got  [64];
    logic [11:0] cmem [64];

    int wr_n = 0, wr_base = 0, addr_err = 0, err_base = 0;

    idct_2d_top dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Start      (Start),
        .Busy       (Busy),
        .Done       (Done),
        .Coef_rd_en (Coef_rd_en),
        .Coef_addr  (Coef_addr),
        .Coef_data  (Coef_data),
        .Pix_wr_en  (Pix_wr_en),
        .Pix_addr   (Pix_addr),
        .Pix_data   (Pix_data),
        .Sat_flag   (Sat_flag)
    );

    always #5 Clk = ~Clk;

    // Coefficient RAM: synchronous read, one cycle latency.
    always @(posedge Clk) begin
        if (Coef_rd_en) Coef_data <= cmem[Coef_addr];
    end

    // Pixel RAM: log every write, checking addresses arrive in order 0..63.
    always @(negedge Clk) begin
        if (Pix_wr_en) begin
            if (Pix_addr != 6'(wr_n - wr_base)) addr_err++;
            pix_got[Pix_addr] = int'(Pix_data);
            wr_n++;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference 2D IDCT straight from the arithmetic rules.
    task automatic model();
        longint t [64];
        longint s, v;
        exp_sat = 0;
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += longint'(kr[k][n]) * coef_blk[r*8+k];
                t[r*8+n] = (s + 64) >>> 7;
            end
        for (int c = 0; c < 8; c++)
            for (int n = 0; n < 8; n++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += longint'(kr[k][n]) * t[k*8+c];
                v = ((s + 64) >>> 7) * 4;
`ifdef IDCT_SAT_EN
                if (v > 255) begin v = 255; exp_sat = 1; end
                else if (v < -256) begin v = -256; exp_sat = 1; end
`else
                v = v & 511;
                if (v >= 256) v -= 512;
`endif
                exp_pix[n*8+c] = int'(v);
            end
    endtask

    // Forward DCT of a random pixel block, pre-scaled by 1/4 as the encoder does.
    task automatic fwd_random_block();
        int  p [64];
        real s, cu, cv;
        for (int i = 0; i < 64; i++) p[i] = int'($urandom_range(255)) - 128;
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                s = 0.0;
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 8; j++)
                        s += p[i*8+j] * $cos((2*i+1)*u*PI/16.0) * $cos((2*j+1)*v*PI/16.0);
                cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                coef_blk[u*8+v] = $rtoi($floor(cu * cv * s / 16.0 + 0.5));
            end
    endtask

    // Run one block; optionally pulse Start at cycle restart_at; linger watches for stray Done pulses.
    task automatic run_block(input int restart_at, input bit linger, input string name);
        int done_at, done_cnt, busy_err;
        done_at = -1; done_cnt = 0; busy_err = 0;
        for (int i = 0; i < 64; i++) cmem[i] = 12'(coef_blk[i]);
        model();
        wr_base  = wr_n;
        err_base = addr_err;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (n > 0) @(negedge Clk);
            if (Done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    check({name, "_busy_at_done"}, Busy, 0);
                end
            end
            if (n >= 1 && n <= DONE_T - 1 && !Busy) busy_err++;
            Start = (n == restart_at);
            if (done_at >= 0 && (!linger || n >= done_at + 4)) break;
        end
        Start = 1'b0;
        check({name, "_done_cycle"}, done_at, DONE_T);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy_window"}, busy_err, 0);
        check({name, "_writes"}, wr_n - wr_base, 64);
        check({name, "_addr_order"}, addr_err - err_base, 0);
        check({name, "_sat"}, Sat_flag, exp_sat);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s_pix%0d", name, i), pix_got[i], exp_pix[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int found, done_seen, base;
        Rst_n = 1'b0;
        Start = 1'b0;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++)
                kr[k][n] = $rtoi($floor(128.0 * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0) / 2.0
                                        * $cos((2*n+1)*k*PI/16.0) + 0.5));

        // Reset state.
        repeat (2) @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_coef_rd_en", Coef_rd_en, 0);
        check("rst_coef_addr", Coef_addr, 0);
        check("rst_pix_wr_en", Pix_wr_en, 0);
        check("rst_pix_addr", Pix_addr, 0);
        check("rst_pix_data", Pix_data, 0);
        check("rst_sat", Sat_flag, 0);
        Rst_n = 1'b1;

        // All-zero block.
        for (int i = 0; i < 64; i++) coef_blk[i] = 0;
        run_block(-1, 1'b1, "zero");

        // DC only, 64 -> every sample 32.
        coef_blk[0] = 64;
        run_block(-1, 1'b1, "dc64");
        check("dc64_const", pix_got[37], 32);

        // DC 2047 -> 1012 before reduction.
        coef_blk[0] = 2047;
        run_block(-1, 1'b1, "dc2047");
`ifdef IDCT_SAT_EN
        check("dc2047_const", pix_got[0], 255);
`else
        check("dc2047_const", pix_got[0], -12);
`endif

        // Start pulsed mid-block is ignored.
        fwd_random_block();
        run_block(40, 1'b1, "restart");

        // Reset during WRITE at address 20 aborts the block.
        fwd_random_block();
        for (int i = 0; i < 64; i++) cmem[i] = 12'(coef_blk[i]);
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        found = 0;
        for (int n = 0; n < 300; n++) begin
            if (Pix_wr_en && Pix_addr == 6'd20) begin found = 1; break; end
            @(negedge Clk);
        end
        check("abort_reached_addr20", found, 1);
        Rst_n = 1'b0;
        @(negedge Clk);
        check("abort_pix_wr_en", Pix_wr_en, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        Rst_n = 1'b1;
        base = wr_n;
        done_seen = 0;
        repeat (200) begin
            @(negedge Clk);
            if (Done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_no_writes", wr_n - base, 0);
        run_block(-1, 1'b1, "after_abort");

        // Back-to-back blocks: second Start in the cycle right after Done.
        fwd_random_block();
        run_block(-1, 1'b0, "b2b_a");
        for (int i = 0; i < 64; i++) coef_blk[i] = int'($urandom_range(4095)) - 2048;
        run_block(-1, 1'b1, "b2b_b");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/idct_2d_top.md
Name: idct_2d_top

Overview:
- 8x8 two-dimensional inverse DCT; the decode-side counterpart of the 2D DCT top.
- Reads 64 signed coefficients row-major from a coefficient RAM read port.
- Runs a row 1D IDCT pass, then a column 1D IDCT pass, with an internal transpose buffer between them.
- Writes 64 reconstructed samples row-major to a pixel RAM write port.
- Start/Busy/Done handshake; one block per Start.

Parameters:
- IN_W, 12, signed coefficient width
- OUT_W, 9, signed output sample width
- INT_W, 24, internal accumulator width
- CF, 7, fractional bits of the cosine constants
- KLAT, 4, 1D kernel pipeline latency in cycles
- OUT_SH, 2, left shift applied after the column pass (undoes the forward-path >>>2)

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  single-cycle request; sampled only in IDLE
- Busy  out  1  high from the cycle after Start is accepted until Done
- Done  out  1  one-cycle pulse when the last sample is written
- Coef_rd_en  out  1  coefficient RAM read enable
- Coef_addr  out  6  coefficient address, row-major (row*8+col)
- Coef_data  in  IN_W  read data, valid 1 cycle after Coef_rd_en
- Pix_wr_en  out  1  pixel RAM write enable
- Pix_addr  out  6  pixel address, row-major
- Pix_data  out  OUT_W  reconstructed sample
- Sat_flag  out  1  sticky saturation indicator (macro only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - Busy, Done, Coef_rd_en, Pix_wr_en, Sat_flag = 0.
  - Coef_addr, Pix_addr, Pix_data = 0.
  - Buffer contents undefined.
  - A reset mid-block aborts it: no Done, and no further writes after reset.
- FSM states IDLE -> LOAD -> ROW -> COL -> WRITE -> DONE -> IDLE.
- IDLE: Start=1 at an edge moves to LOAD; Busy=1 from the next cycle.
- LOAD (65 cycles):
  - Coef_rd_en=1 with Coef_addr 0..63 on cycles 0..63.
  - Coef_data is captured into coefficient buffer entry Coef_addr-1 on cycles 1..64.
- ROW (8+KLAT cycles):
  - One row (8 values) is issued to the kernel per cycle for 8 cycles.
  - Kernel outputs are valid KLAT cycles after issue.
  - Outputs of row r are written into transpose buffer row r.
- COL (8+KLAT cycles):
  - Column c of the transpose buffer is issued per cycle.
  - Results are written into output buffer column c.
- WRITE (64 cycles): Pix_wr_en=1, Pix_addr 0..63, Pix_data = output buffer entry, registered.
- DONE (1 cycle): Done=1, Busy=0, then return to IDLE.
- Timing: Done asserts exactly 2*(8+KLAT)+129 cycles after the Start-sampling edge (153 at defaults). Back-to-back Start is accepted the cycle after Done.
- Start while Busy is ignored, with no effect on the current block.
- Kernel arithmetic:
  - x[n] = sum_k K[k][n]*X[k], where K = round(2^CF * C(k)/2 * cos((2n+1)k*pi/16)) and C(0)=1/sqrt2, else 1.
  - K[0][*] = 45 at CF=7.
  - Products and sums are carried in INT_W signed bits.
  - Each pass result = (sum + 2^(CF-1)) >>> CF, stored at INT_W.
- Final output = (col result <<< OUT_SH), reduced to OUT_W as described under Optional Feature.

Optional Feature:
- Macro: IDCT_SAT_EN.
- Defined:
  - Final value saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Sat_flag sets on any clipped sample and stays set until the next accepted Start or reset.
- Undefined:
  - Final value is truncated to its low OUT_W bits (two's-complement wrap).
  - Sat_flag is constant 0.

Decomposition:
- Package idct_pkg holds:
  - the 8x8 cosine constant table K (CF-scaled integers);
  - the FSM state encoding;
  - phase length constants: LOAD_CYC=65, PASS_CYC=8+KLAT, WRITE_CYC=64.
- Sub-module one_d_idct_kernel:
  - 8 inputs and 8 outputs, fully pipelined with latency KLAT.
  - Instantiated once and time-shared between the ROW and COL passes.

Test Plan:
- All 64 coefficients 0 -> 64 writes of 0 at addresses 0..63; Done at cycle 153; Busy high for cycles 1..152.
- DC only, X[0][0]=64, rest 0 -> every Pix_data = 32 (64*45 -> 23 -> 8, then <<2 = 32).
- X[0][0]=2047 -> col result 253, <<2 = 1012:
  - with IDCT_SAT_EN, all outputs 255 and Sat_flag=1;
  - without, all outputs -12 and Sat_flag=0.
- Start pulsed again at cycle 40 of a block -> ignored; exactly 64 writes; single Done at 153.
- Rst_n low during WRITE at Pix_addr=20 -> next cycle Pix_wr_en=0, Busy=0, no Done; a following Start completes a full block.
- Coefficients from a forward-DCT golden model of a random 8x8 block -> every sample matches the integer reference model above bit-exactly.
